// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  localparam int unsigned XLEN               = 64;
  localparam int unsigned INST_W             = 32;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 2;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 64'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACCEPT,
    WAIT_RESP
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fifo_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO for fetched instructions: registered storage, no
// fall-through, flush empties it; head reads as zero while empty.
module ifu_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 96
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_next;
  logic             do_push;
  logic             do_pop;
  logic             full;

  assign full     = (count == CNT_W'(DEPTH));
  assign do_pop   = pop && valid;
  assign do_push  = push && !flush && (!full || do_pop);
  assign pop_data = valid ? mem[rd_ptr] : '0;

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_next = count - CNT_W'(1);
    end
  end

  // Pointers, occupancy and valid flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
      valid <= (count_next != '0);
    end
  end

  // Storage array; contents are don't-care while not valid
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding 32-bit fetch, small instruction
// buffer towards decode, redirects flush buffer and discard in-flight fetch.
// Optional build macro IFU_PERF_CNT_EN adds fetch/drop performance counters.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned     FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [XLEN-1:0]   req_addr,
  input  logic              resp_valid,
  input  logic [INST_W-1:0] resp_data,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [XLEN-1:0]   out_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [XLEN-1:0]   perf_fetch_cnt,
  output logic [XLEN-1:0]   perf_drop_cnt
`endif
);

  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ENTRY_W = $bits(fifo_entry_t);

  state_t            state;
  state_t            state_next;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   pc_next;
  logic [XLEN-1:0]   req_addr_next;
  logic [XLEN-1:0]   redirect_target;
  logic              stale;
  logic              stale_next;
  logic              req_valid_next;
  logic              push;
  fifo_entry_t       push_entry;
  fifo_entry_t       head;
  logic [ENTRY_W-1:0] head_bits;
  logic [CNT_W-1:0]  fifo_count;
  logic              unused_redirect_lsb;

  assign redirect_target     = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // The outstanding fetch address stays in req_addr until the next issue
  assign push_entry = '{pc: req_addr, inst: resp_data};
  assign head       = fifo_entry_t'(head_bits);
  assign out_inst   = head.inst;
  assign out_pc     = head.pc;

  // Instruction buffer between fetch and decode
  ifu_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (out_ready),
    .flush     (redirect_valid),
    .pop_data  (head_bits),
    .valid     (out_valid),
    .count     (fifo_count)
  );

  // Fetch sequencing, PC update and stale tracking
  always_comb begin
    state_next     = state;
    pc_next        = pc;
    stale_next     = stale;
    req_valid_next = req_valid;
    req_addr_next  = req_addr;
    push           = 1'b0;

    case (state)
      IDLE: begin
        // Issue only when the response is guaranteed a free slot
        if (!redirect_valid && (fifo_count < CNT_W'(FIFO_DEPTH))) begin
          req_valid_next = 1'b1;
          req_addr_next  = pc;
          state_next     = WAIT_ACCEPT;
        end
      end
      WAIT_ACCEPT: begin
        if (req_ready) begin
          req_valid_next = 1'b0;
          state_next     = WAIT_RESP;
          // A stale fetch must not advance the redirected PC
          if (!stale) pc_next = pc + XLEN'(4);
        end
      end
      WAIT_RESP: begin
        if (resp_valid) begin
          push       = !stale && !redirect_valid;
          stale_next = 1'b0;
          state_next = IDLE;
        end
      end
      default: begin
        state_next     = IDLE;
        req_valid_next = 1'b0;
      end
    endcase

    // Redirect overrides PC; any fetch still awaiting its response is discarded
    if (redirect_valid) begin
      pc_next = redirect_target;
      if ((state == WAIT_ACCEPT) || ((state == WAIT_RESP) && !resp_valid)) begin
        stale_next = 1'b1;
      end
    end
  end

  // State, PC and request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      stale     <= 1'b0;
      req_valid <= 1'b0;
      req_addr  <= RESET_PC;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      stale     <= stale_next;
      req_valid <= req_valid_next;
      req_addr  <= req_addr_next;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic drop;

  assign drop = (state == WAIT_RESP) && resp_valid && (stale || redirect_valid);

  // Pushed-instruction and dropped-response counters, wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_drop_cnt  <= '0;
    end else begin
      if (push) perf_fetch_cnt <= perf_fetch_cnt + XLEN'(1);
      if (drop) perf_drop_cnt  <= perf_drop_cnt + XLEN'(1);
    end
  end
`endif

endmodule

// File: tb/tb_ifu.sv
// Testbench for ifu: memory model, directed scenarios, random phase, and a
// scoreboard expecting a consecutive-PC stream from the last redirect/reset.
module tb_ifu;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [63:0] out_pc;

  int checks = 0;
  int failures = 0;
  int delivered = 0;

  // memory model state and knobs
  int          cyc = 0;
  bit          pending = 0;
  logic [63:0] p_addr = '0;
  int          resp_at = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          ready_mode = 0;
  int          acc_total = 0;
  logic [63:0] last_acc = '0;
  bit          prev_wait = 0;
  logic [63:0] prev_addr = '0;

  exp_t        exp_q[$];
  logic [63:0] exp_next;

  ifu dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: 0x13 at the reset PC, distinct elsewhere
  function automatic logic [31:0] word(input logic [63:0] a);
    logic [31:0] x;
    x = a[31:0] ^ a[63:32];
    x = x - 32'h8000_0000;
    return 32'h0000_0013 ^ (x * 32'h9E37_79B1);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic topup();
    exp_t e;
    while (exp_q.size() < 8) begin
      e.pc   = exp_next;
      e.inst = word(exp_next);
      exp_q.push_back(e);
      exp_next = exp_next + 64'd4;
    end
  endtask

  task automatic reseed(input logic [63:0] r);
    exp_q.delete();
    exp_next = {r[63:2], 2'b00};
    topup();
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    topup();
  endtask

  task automatic wait_acc(input string name, input int n0);
    int k;
    k = 0;
    while (acc_total == n0 && k < 100) begin
      step();
      k++;
    end
    if (acc_total == n0) begin
      checks++;
      failures++;
      $display("FAIL %s timeout waiting for request accept", name);
    end
  endtask

  task automatic do_redirect(input logic [63:0] r);
    redirect_valid = 1'b1;
    redirect_pc    = r;
    reseed(r);
    step();
    redirect_valid = 1'b0;
    chk("out_valid_after_redirect", 64'(out_valid), 64'd0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_valid", 64'(req_valid), 64'd0);
    chk("rst_req_addr", req_addr, RST_PC);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_inst", 64'(out_inst), 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
  endtask

  // Instruction memory: accepts at negedge, replies lat cycles later
  initial begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (pending && cyc == resp_at) begin
        resp_valid = 1'b1;
        resp_data  = word(p_addr);
        pending    = 0;
      end else begin
        resp_valid = 1'b0;
        resp_data  = $urandom;
      end
      case (ready_mode)
        0:       req_ready = 1'b1;
        1:       req_ready = 1'($urandom_range(0, 1));
        default: req_ready = 1'b0;
      endcase
      @(negedge clk);
      if (rst) begin
        prev_wait = 0;
      end else begin
        if (prev_wait) begin
          chk("req_hold_valid", 64'(req_valid), 64'd1);
          chk("req_hold_addr", req_addr, prev_addr);
        end
        if (req_valid) chk("req_addr_align", 64'(req_addr[1:0]), 64'd0);
        if (req_valid && req_ready) begin
          if (pending) begin
            checks++;
            failures++;
            $display("FAIL two_outstanding actual=%h with pending=%h", req_addr, p_addr);
          end
          pending   = 1;
          p_addr    = req_addr;
          resp_at   = cyc + int'($urandom_range(lat_min, lat_max));
          acc_total++;
          last_acc  = req_addr;
        end
        prev_wait = req_valid && !req_ready;
        prev_addr = req_addr;
      end
    end
  end

  // Scoreboard monitor: every delivered instruction must match the queue head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_empty actual_pc=%h expected=none", out_pc);
        end else begin
          e = exp_q.pop_front();
          chk("sb_out_pc", out_pc, e.pc);
          chk("sb_out_inst", 64'(out_inst), 64'(e.inst));
        end
        delivered++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n0;
    int k;
    logic [63:0] a0;
    logic [63:0] tgt;

    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    reseed(RST_PC);
    repeat (3) step();
    chk_reset_outputs();

    // reset release and first fetch
    out_ready = 1'b1;
    rst       = 1'b0;
    step();
    chk("first_req_valid", 64'(req_valid), 64'd1);
    chk("first_req_addr", req_addr, RST_PC);
    k = 0;
    while (!resp_valid && k < 20) begin
      step();
      k++;
    end
    chk("first_resp_seen", 64'(resp_valid), 64'd1);
    chk("first_acc_addr", last_acc, 64'h8000_0000);
    step();
    chk("first_out_valid", 64'(out_valid), 64'd1);
    chk("first_out_pc", out_pc, 64'h8000_0000);
    chk("first_out_inst", 64'(out_inst), 64'h0000_0013);
    wait_acc("second_acc", acc_total);
    chk("second_acc_addr", last_acc, 64'h8000_0004);

    // steady-state throughput: one fetch every 3 cycles
    repeat (6) step();
    n0 = acc_total;
    repeat (30) step();
    chk("throughput_30cyc", 64'(acc_total - n0), 64'd10);

    // decode stalled: buffer fills to two and fetching stops
    out_ready = 1'b0;
    do_redirect(64'h8000_2000);
    repeat (12) step();
    chk("stall_out_valid", 64'(out_valid), 64'd1);
    chk("stall_out_pc", out_pc, 64'h8000_2000);
    chk("stall_last_acc", last_acc, 64'h8000_2004);
    chk("stall_req_valid", 64'(req_valid), 64'd0);
    step();
    chk("stall_req_valid_hold", 64'(req_valid), 64'd0);
    out_ready = 1'b1;
    repeat (10) step();

    // memory not ready: request held, PC advances only on accept
    ready_mode = 2;
    step();
    k = 0;
    while (!req_valid && k < 20) begin
      step();
      k++;
    end
    a0 = req_addr;
    n0 = acc_total;
    repeat (5) begin
      step();
      chk("noready_valid", 64'(req_valid), 64'd1);
      chk("noready_addr", req_addr, a0);
    end
    chk("noready_no_accept", 64'(acc_total), 64'(n0));
    ready_mode = 0;
    wait_acc("noready_acc", acc_total);
    chk("noready_acc_addr", last_acc, a0);
    wait_acc("noready_next", acc_total);
    chk("noready_next_addr", last_acc, a0 + 64'd4);

    // redirect while waiting for a response
    lat_min = 3;
    lat_max = 3;
    repeat (4) step();
    wait_acc("t4_acc", acc_total);
    do_redirect(64'h8000_1000);
    wait_acc("t4_next", acc_total);
    chk("t4_next_addr", last_acc, 64'h8000_1000);
    k = 0;
    while (!out_valid && k < 20) begin
      step();
      k++;
    end
    chk("t4_first_out_pc", out_pc, 64'h8000_1000);

    // redirect coincident with a response and with a pop
    lat_min   = 1;
    lat_max   = 1;
    out_ready = 1'b0;
    k = 0;
    step();
    while (!(resp_valid && out_valid) && k < 60) begin
      step();
      k++;
    end
    chk("t5_setup", 64'(resp_valid && out_valid), 64'd1);
    out_ready = 1'b1;
    do_redirect(64'h8000_3000);
    wait_acc("t5_next", acc_total);
    chk("t5_next_addr", last_acc, 64'h8000_3000);
    repeat (10) step();

    // reset in the middle of an outstanding fetch
    lat_min = 3;
    lat_max = 3;
    wait_acc("t6_acc", acc_total);
    rst = 1'b1;
    reseed(RST_PC);
    step();
    chk_reset_outputs();
    rst = 1'b0;
    wait_acc("t6_next", acc_total);
    chk("t6_next_addr", last_acc, RST_PC);
    repeat (10) step();

    // random traffic
    lat_min    = 1;
    lat_max    = 4;
    ready_mode = 1;
    n0         = delivered;
    for (int i = 0; i < 3000; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) begin
        tgt = 64'h8000_0000 + 64'($urandom_range(0, 16383)) * 64'd4;
        tgt[1:0] = 2'($urandom_range(0, 3));
        do_redirect(tgt);
      end else begin
        step();
      end
    end
    chk("random_progress", 64'(delivered - n0 >= 100), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
